// File: rtl/probe_disp_pkg.sv
// Shared constants and helpers for the probe display engine: seven-segment
// font, blank pattern, ceil-log2 and the parameter legality rule.
package probe_disp_pkg;

  // All segments off (dp included), active-low
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Hex font, active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Ceiling log2; returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // True when the parameter set describes a buildable engine
  function automatic bit params_ok(input int unsigned num_ch,
                                   input int unsigned data_w,
                                   input int unsigned num_digits,
                                   input int unsigned refresh_w,
                                   input int unsigned dead);
    int unsigned dig_w;
    bit          ok;
    dig_w = clog2(num_digits);
    ok = 1'b1;
    if (num_ch < 2) ok = 1'b0;
    if (num_digits < 2 || (num_digits & (num_digits - 1)) != 0) ok = 1'b0;
    if (data_w == 0 || (data_w % (4 * num_digits)) != 0) ok = 1'b0;
    if (refresh_w < dig_w + 3 || refresh_w > 31) ok = 1'b0;
    else if (64'(dead) >= (64'd1 << (refresh_w - dig_w))) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern {g..a}.
module hex_to_sseg
  import probe_disp_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Font lookup
  always_comb begin
    seg = SEG_FONT[hex];
  end

endmodule

// File: rtl/probe_disp_scan.sv
// Multi-channel probe display: selects a channel/nibble window, captures it
// under freeze/step control and scans it onto active-low seven-segment digits
// with a per-slot dead time and optional leading-zero blanking.
module probe_disp_scan
  import probe_disp_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned REFRESH_W  = 18,
  parameter int unsigned DEAD       = 4,
  localparam int unsigned SEL_W     = clog2(NUM_CH),
  localparam int unsigned NWIN      = DATA_W / (4 * NUM_DIGITS),
  localparam int unsigned WIN_W     = (NWIN > 1) ? clog2(NWIN) : 1,
  localparam int unsigned DIG_W     = clog2(NUM_DIGITS),
  localparam int unsigned VAL_W     = 4 * NUM_DIGITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [SEL_W-1:0]         ch_sel,
  input  logic [WIN_W-1:0]         win_sel,
  input  logic                     freeze,
  input  logic                     step,
  input  logic                     blank_lz,
  input  logic [NUM_DIGITS-1:0]    dp_in,
  output logic [NUM_DIGITS-1:0]    an,
  output logic [7:0]               sseg,
  output logic [VAL_W-1:0]         disp_val,
  output logic                     sel_err
);

  localparam int unsigned SLOT_W = REFRESH_W - DIG_W;

  // One extra bit so the limit itself is representable
  localparam logic [SEL_W:0]    CH_LIMIT  = (SEL_W + 1)'(NUM_CH);
  localparam logic [WIN_W:0]    WIN_LIMIT = (WIN_W + 1)'(NWIN);
  localparam logic [SLOT_W-1:0] DEAD_L    = SLOT_W'(DEAD);

  if (!params_ok(NUM_CH, DATA_W, NUM_DIGITS, REFRESH_W, DEAD)) begin : g_bad_params
    $error("probe_disp_scan: illegal parameter combination");
  end

  logic [VAL_W-1:0]     cap_q;
  logic                 step_q;
  logic [REFRESH_W-1:0] scnt_q;

  logic                 sel_bad;
  logic [VAL_W-1:0]     raw;
  logic                 cap_load;
  logic [DIG_W-1:0]     digit;
  logic [SLOT_W-1:0]    slot_off;
  logic                 in_dead;
  logic [DIG_W-1:0]     msd;
  logic                 lz_blank;
  logic [3:0]           nibble;
  logic [6:0]           seg;
  logic                 dp_sel;
  logic [NUM_DIGITS-1:0] digit_onehot;

  // Out-of-range channel or window selects a zero value
  always_comb begin
    sel_bad = ({1'b0, ch_sel} >= CH_LIMIT) || ({1'b0, win_sel} >= WIN_LIMIT);
  end

  // Channel/window mux
  always_comb begin
    raw = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      for (int w = 0; w < int'(NWIN); w++) begin
        if (!sel_bad && ch_sel == SEL_W'(k) && win_sel == WIN_W'(w)) begin
          raw = ch_data[k*DATA_W + w*VAL_W +: VAL_W];
        end
      end
    end
  end

  // Live capture when running; one capture per step rising edge when frozen
  always_comb begin
    cap_load = !freeze || (step && !step_q);
  end

  // Capture register, step edge detector and select error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_q   <= '0;
      step_q  <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      step_q  <= step;
      sel_err <= sel_bad;
      if (cap_load) cap_q <= raw;
    end
  end

  // Free-running scan counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_q + 1'b1;
    end
  end

  // Split the scan counter into digit index and slot offset
  always_comb begin
    digit    = scnt_q[REFRESH_W-1 -: DIG_W];
    slot_off = scnt_q[SLOT_W-1:0];
    in_dead  = slot_off < DEAD_L;
  end

  // Most significant nonzero nibble; stays 0 for an all-zero value
  always_comb begin
    msd = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (cap_q[i*4 +: 4] != 4'h0) msd = DIG_W'(i);
    end
  end

  // Digit 0 can never exceed msd, so it is never blanked
  always_comb begin
    lz_blank = blank_lz && (digit > msd);
  end

  // Current digit's nibble, decimal point and anode pattern
  always_comb begin
    nibble = 4'h0;
    dp_sel = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (digit == DIG_W'(i)) begin
        nibble = cap_q[i*4 +: 4];
        dp_sel = dp_in[i];
      end
    end
    digit_onehot = NUM_DIGITS'(1) << digit;
  end

  hex_to_sseg u_hex_to_sseg (
    .hex (nibble),
    .seg (seg)
  );

  // Registered pin drivers; dead time keeps anodes off across digit changes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an   <= '1;
      sseg <= SEG_BLANK;
    end else if (in_dead || lz_blank) begin
      an   <= '1;
      sseg <= SEG_BLANK;
    end else begin
      an   <= ~digit_onehot;
      sseg <= {dp_sel, seg};
    end
  end

  assign disp_val = cap_q;

endmodule

// File: doc/probe_disp_scan.md
# probe_disp_scan

Parametrised multi-channel probe display engine for FPGA bring-up of the pipelined MIPS core. It selects one of NUM_CH DATA_W-bit probe channels (PC, instr, ALU out, write data, register-file read port, ...) and a nibble window within it. It captures the value with freeze/single-step control and time-multiplexes it onto NUM_DIGITS active-low seven-segment digits with dead-time and leading-zero blanking. It replaces the fixed 4-digit PC/byte scheme in the top level and sits between the core's probe wires and the board pins.

## Interface
- NUM_CH, 8: probe channel count, ≥2.
- DATA_W, 32: channel width; multiple of 4*NUM_DIGITS.
- NUM_DIGITS, 4: digit count; power of 2, ≥2.
- REFRESH_W, 18: scan counter width; ≥ log2(NUM_DIGITS)+3.
- DEAD, 4: blank cycles at start of each digit slot; < slot length.
- Derived: SEL_W=clog2(NUM_CH), NWIN=DATA_W/(4*NUM_DIGITS), WIN_W=max(1,clog2(NWIN)), DIG_W=clog2(NUM_DIGITS).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ch_data  in  NUM_CH*DATA_W  flattened channels; channel k at [k*DATA_W +: DATA_W].
- ch_sel  in  SEL_W  channel select.
- win_sel  in  WIN_W  nibble window; window w = bits [w*4*NUM_DIGITS +: 4*NUM_DIGITS].
- freeze  in  1  level; hold captured value.
- step  in  1  while frozen, rising edge recaptures once.
- blank_lz  in  1  enable leading-zero blanking.
- dp_in  in  NUM_DIGITS  decimal points, active-low, per digit.
- an  out  NUM_DIGITS  anodes, active-low, registered.
- sseg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
- disp_val  out  4*NUM_DIGITS  currently captured value.
- sel_err  out  1  registered; ch_sel ≥ NUM_CH or win_sel ≥ NWIN.

## Operation
- Select: raw = window win_sel of channel ch_sel. If either select is out of range, raw = 0 and sel_err=1.
- Capture register cap:
  - freeze=0: cap <= raw every cycle.
  - freeze=1: cap holds.
  - A step rising edge (step=1, step_q=0) while freeze=1 loads cap once.
  - step is ignored while freeze=0.
  - disp_val = cap.
- Scan counter scnt, REFRESH_W bits, free-running, wraps to 0.
  - Digit index d = scnt[REFRESH_W-1 -: DIG_W].
  - Slot offset = the lower bits of scnt. Slot length S = 2^(REFRESH_W-DIG_W).
- Leading-zero blanking: msd = index of the highest nonzero nibble of cap, 0 if cap==0. With blank_lz=1, digits d>msd are blanked. Digit 0 is never blanked.
- Output registers, updated every cycle:
  - Blanked digit, or slot offset < DEAD: an=all 1, sseg=8'hFF.
  - Otherwise: an=~(1<<d), sseg={dp_in[d], seg7(cap nibble d)}.
- seg7 is the standard hex font 0–F, active-low. Example: 0→7'b1000000, 8→7'b0000000, F→7'b0001110 (g..a).

## Timing
- Reset asserted: scnt=0, cap=0, step_q=0, an=all 1, sseg=8'hFF, disp_val=0, sel_err=0. Takes effect immediately, including mid-scan.
- After deassert, the first lit digit is digit 0: an goes low on the edge after scnt reaches DEAD.
- Latency:
  - raw → cap: 1 cycle.
  - cap/scnt → an/sseg: 1 cycle. Total input→pins: 2 cycles.
- freeze asserted in cycle t: cap keeps the value captured at edge t. No update is taken at that edge.
- step and freeze rising together: the step edge is honoured, giving one capture.
- sel changes while frozen: only sel_err updates; cap is unaffected.
- scnt wrap (all 1 → 0): d returns to 0 and a dead period follows. There are no glitch cycles with two anodes low.

## Structure
- Package probe_disp_pkg holds:
  - SEG_FONT[16] constants;
  - SEG_BLANK=8'hFF;
  - clog2 helper function;
  - parameter legality checks (elaboration-time asserts).
- Sub-module hex_to_sseg (combinational, 4-bit in → 7-bit active-low) is instantiated once on the selected nibble.
- All state is in the top: cap, step_q, scnt, output regs.

## Test plan
- Reset/idle: REFRESH_W=6, NUM_DIGITS=4, DEAD=2, reset low mid-scan → an=4'b1111, sseg=8'hFF immediately. After release, digit 0 lights at cycle 3 and the slot is 16 cycles.
- Channel/window select: ch 2 = 32'hDEADBEEF, ch_sel=2.
  - win_sel=1: disp_val=16'hDEAD; digit 3 shows sseg 7'b0100001 (d).
  - win_sel=0: disp_val=16'hBEEF.
- Freeze/step: freeze=1 with cap=16'h1234, then channel changes to 16'h5678 → cap stays 1234. A one-cycle step pulse → cap=5678 two cycles later; holding step high gives no further updates.
- Leading-zero blanking: cap=16'h0040, blank_lz=1 → digits 2,3 are never lit; digits 0,1 show 0 and 4. cap=0 → only digit 0 lights, showing 0.
- Select error: NUM_CH=6, ch_sel=7 → disp_val=0 and sel_err=1 one cycle later. ch_sel=5 clears it.
- Scan integrity over 4 full wraps: never more than one an bit low; the dead cycles count is exactly DEAD per slot; dp_in=4'b1110 drives sseg[7]=0 only while digit 0 is lit.
